multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the team's single-edge detector. Synchronises a WIDTH-bit asynchronous input bus and detects rising, falling or both edges per channel, selected at run time. Each channel has a programmable lockout (deglitch) window, a sticky flag with clear, and a shared saturating event counter. It sits between raw GPIO/sensor inputs and the interrupt/status logic.

---
 rtl/multi_edge_detector.sv | 185 ++++++++++++++++++
 tb/tb_multi_edge_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector for raw GPIO/sensor levels. Each channel is
//   synchronised, compared against its previous level, and qualified by a
//   run-time edge mode, a per-channel lockout window and a global warm-up
//   window after reset. Qualified edges produce registered one-cycle pulses,
//   a sticky per-channel flag and a shared saturating event count.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in          raw channel levels (WIDTH)
//   mode        00 rising, 01 falling, 10 both, 11 disabled (all channels)
//   clr_sticky  per-channel synchronous clear of sticky
//   cnt_clr     synchronous clear of evt_count
//   evt         one-cycle pulse per qualified edge
//   rise/fall   evt split by edge direction
//   any_evt     OR of evt
//   sticky      evt latched until cleared (set beats clear)
//   evt_count   saturating count of qualified edges

// Per-channel front end: synchroniser, previous-level register, lockout
// counter. Produces the qualified edge strobes for the current cycle; all
// output registers live in the top so the lanes stay purely per-channel.
module multi_edge_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCKOUT     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic       warm,
  input  logic [1:0] mode,
  output logic       hit_rise,
  output logic       hit_fall
);
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  localparam int LW = (LOCKOUT < 2) ? 1 : $clog2(LOCKOUT + 1);

  logic          s;
  logic          prev;
  logic [LW-1:0] lock;
  mode_e         m;
  logic          want_rise;
  logic          want_fall;
  logic          open;
  logic          diff;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync <= '0;
        end else begin
          sync[0] <= raw;
          for (int j = 1; j < SYNC_STAGES; j++) sync[j] <= sync[j-1];
        end
      end
      assign s = sync[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    m         = mode_e'(mode);
    want_rise = (m == MODE_RISE) || (m == MODE_BOTH);
    want_fall = (m == MODE_FALL) || (m == MODE_BOTH);
    diff      = s ^ prev;
    // Edges seen while locked out or warming up are dropped outright.
    open      = warm && (lock == '0);
    hit_rise  = open && diff && s && want_rise;
    hit_fall  = open && diff && !s && want_fall;
  end

  // prev tracks s unconditionally so a dropped edge is never replayed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      lock <= '0;
    end else begin
      prev <= s;
      if (hit_rise || hit_fall) lock <= LW'(LOCKOUT);
      else if (lock != '0)      lock <= lock - LW'(1);
    end
  end
endmodule

module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCKOUT     = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     clr_sticky,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     evt,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 any_evt,
  output logic [WIDTH-1:0]     sticky,
  output logic [CNT_WIDTH-1:0] evt_count
);
  // Warm-up spans the synchroniser fill plus one edge to load prev, so a
  // level that was already high at reset never reads as a rising edge.
  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);
  // Popcount width and a sum width wide enough to hold count + popcount
  // without wrapping before the saturation compare.
  localparam int PW   = $clog2(WIDTH + 1);
  localparam int SW   = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CNT_WIDTH) - SW'(1);

  logic [WW-1:0]        warm_cnt;
  logic                 warm;
  logic [WIDTH-1:0]     rise_next;
  logic [WIDTH-1:0]     fall_next;
  logic [WIDTH-1:0]     evt_next;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        sum;
  logic [CNT_WIDTH-1:0] count_next;

  assign warm = (warm_cnt == WW'(WARM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        warm_cnt <= '0;
    else if (!warm) warm_cnt <= warm_cnt + WW'(1);
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      multi_edge_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCKOUT     (LOCKOUT)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .raw      (in[i]),
        .warm     (warm),
        .mode     (mode),
        .hit_rise (rise_next[i]),
        .hit_fall (fall_next[i])
      );
    end
  endgenerate

  assign evt_next = rise_next | fall_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(evt_next[i]);
    // cnt_clr drops the old total but still counts this cycle's events.
    sum = SW'(pop);
    if (!cnt_clr) sum = sum + SW'(evt_count);
    count_next = (sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt       <= '0;
      rise      <= '0;
      fall      <= '0;
      any_evt   <= 1'b0;
      sticky    <= '0;
      evt_count <= '0;
    end else begin
      evt       <= evt_next;
      rise      <= rise_next;
      fall      <= fall_next;
      any_evt   <= |evt_next;
      sticky    <= (sticky & ~clr_sticky) | evt_next;
      evt_count <= count_next;
    end
  end
endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;
  localparam logic [1:0] M_RISE = 2'b00;
  localparam logic [1:0] M_FALL = 2'b01;
  localparam logic [1:0] M_BOTH = 2'b10;
  localparam logic [1:0] M_OFF  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: defaults (SYNC 2, LOCKOUT 1, CNT 16)
  logic [7:0]  in_a, clr_a, evt_a, rise_a, fall_a, sticky_a;
  logic [1:0]  mode_a;
  logic        cclr_a, any_a;
  logic [15:0] cnt_a;
  // dut_b: LOCKOUT 3, CNT 4
  logic [7:0]  in_b, clr_b, evt_b, rise_b, fall_b, sticky_b;
  logic [1:0]  mode_b;
  logic        cclr_b, any_b;
  logic [3:0]  cnt_b;
  // dut_c: 2 channels, sync bypass, no lockout
  logic [1:0]  in_c, clr_c, evt_c, rise_c, fall_c, sticky_c;
  logic [1:0]  mode_c;
  logic        cclr_c, any_c;
  logic [7:0]  cnt_c;

  multi_edge_detector dut_a (
    .clk(clk), .rst(rst), .in(in_a), .mode(mode_a), .clr_sticky(clr_a),
    .cnt_clr(cclr_a), .evt(evt_a), .rise(rise_a), .fall(fall_a),
    .any_evt(any_a), .sticky(sticky_a), .evt_count(cnt_a));

  multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .LOCKOUT(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .mode(mode_b), .clr_sticky(clr_b),
    .cnt_clr(cclr_b), .evt(evt_b), .rise(rise_b), .fall(fall_b),
    .any_evt(any_b), .sticky(sticky_b), .evt_count(cnt_b));

  multi_edge_detector #(.WIDTH(2), .SYNC_STAGES(0), .LOCKOUT(0), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .in(in_c), .mode(mode_c), .clr_sticky(clr_c),
    .cnt_clr(cclr_c), .evt(evt_c), .rise(rise_c), .fall(fall_c),
    .any_evt(any_c), .sticky(sticky_c), .evt_count(cnt_c));

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  in;
    logic [1:0]  mode;
    logic [7:0]  clr;
    logic        cclr;
    logic [7:0]  evt;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [7:0]  sticky;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] i, input logic [1:0] m, input logic [7:0] c,
                     input logic cc, input logic [7:0] e, input logic [7:0] r,
                     input logic [7:0] f, input logic [7:0] s, input logic [15:0] n);
    vec_t v;
    v.in = i; v.mode = m; v.clr = c; v.cclr = cc;
    v.evt = e; v.rise = r; v.fall = f; v.sticky = s; v.cnt = n;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    in_a = 8'hFF; mode_a = M_RISE; clr_a = '0; cclr_a = 1'b0;
    in_b = '0;    mode_b = M_RISE; clr_b = '0; cclr_b = 1'b0;
    in_c = '0;    mode_c = M_RISE; clr_c = '0; cclr_c = 1'b0;

    // Input is applied before edge k; edge k compares the levels sampled
    // at k-2 and k-3 (two sync stages), so a change shows two rows later.
    //   in     mode    clr    cc    evt    rise   fall   sticky cnt
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0); // r0
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0); // FF->00 ignored
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'h08, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0); // r4 ch3 up
    add(8'h08, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'h08, M_RISE, 8'h00, 1'b0, 8'h08, 8'h08, 8'h00, 8'h08, 1); // r6
    add(8'h08, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1); // r8 ch3 down
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    add(8'h00, M_RISE, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1); // fall ignored
    add(8'h01, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1); // r11 ch0 toggles
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    add(8'h01, M_BOTH, 8'h00, 1'b0, 8'h01, 8'h01, 8'h00, 8'h09, 2); // r13
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 2); // locked out
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h01, 8'h01, 8'h00, 8'h09, 3); // r15
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 3); // locked out
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 3);
    add(8'h20, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 3); // r18 ch5 up
    add(8'h20, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 3);
    add(8'h20, M_BOTH, 8'h20, 1'b0, 8'h20, 8'h20, 8'h00, 8'h29, 4); // set beats clr
    add(8'h20, M_BOTH, 8'h20, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 4); // clr alone
    add(8'h20, M_BOTH, 8'h01, 1'b1, 8'h00, 8'h00, 8'h00, 8'h08, 0); // r22
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 0); // ch5 down
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 0);
    add(8'h00, M_BOTH, 8'h00, 1'b0, 8'h20, 8'h00, 8'h20, 8'h28, 1); // r25
    add(8'h80, M_OFF,  8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h28, 1); // r26 ch7 up
    add(8'h80, M_OFF,  8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h28, 1);
    add(8'h80, M_OFF,  8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h28, 1); // disabled
    add(8'h00, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h28, 1); // r29 ch7 down
    add(8'h00, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h28, 1);
    add(8'h00, M_FALL, 8'h00, 1'b0, 8'h80, 8'h00, 8'h80, 8'hA8, 2); // r31
    add(8'h02, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA8, 2); // ch1 up
    add(8'h02, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA8, 2);
    add(8'h02, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA8, 2); // rise ignored
    add(8'h02, M_FALL, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA8, 2);

    // Reset held with all inputs high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_evt", evt_a, 8'h00);
    chk("rst_sticky", sticky_a, 8'h00);
    chk("rst_cnt", cnt_a, 16'd0);
    chk("rst_any", any_a, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("warm_evt%0d", k), evt_a, 8'h00);
    end
    chk("warm_sticky", sticky_a, 8'h00);
    chk("warm_cnt", cnt_a, 16'd0);

    // Table-driven run on dut_a.
    for (int i = 0; i < tbl.size(); i++) begin
      in_a = tbl[i].in; mode_a = tbl[i].mode; clr_a = tbl[i].clr; cclr_a = tbl[i].cclr;
      tick();
      chk($sformatf("a_r%0d_evt", i), evt_a, tbl[i].evt);
      chk($sformatf("a_r%0d_rise", i), rise_a, tbl[i].rise);
      chk($sformatf("a_r%0d_fall", i), fall_a, tbl[i].fall);
      chk($sformatf("a_r%0d_any", i), any_a, |tbl[i].evt);
      chk($sformatf("a_r%0d_sticky", i), sticky_a, tbl[i].sticky);
      chk($sformatf("a_r%0d_cnt", i), cnt_a, tbl[i].cnt);
    end
    clr_a = '0; cclr_a = 1'b0;

    // dut_c: no sync, no lockout, toggling every cycle -> evt every cycle.
    mode_c = M_BOTH;
    for (int k = 0; k < 8; k++) begin
      in_c = (k % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      chk($sformatf("c_evt%0d", k), evt_c, 2'b01);
      chk($sformatf("c_rise%0d", k), rise_c, (k % 2 == 0) ? 2'b01 : 2'b00);
      chk($sformatf("c_fall%0d", k), fall_c, (k % 2 == 0) ? 2'b00 : 2'b01);
      chk($sformatf("c_cnt%0d", k), cnt_c, 8'(k + 1));
    end
    in_c = 2'b00;
    tick();
    chk("c_quiet_evt", evt_c, 2'b00);
    chk("c_quiet_cnt", cnt_c, 8'd8);

    // dut_b: LOCKOUT=3, ch0 toggling every cycle. Raw edges at edges 2..17;
    // qualified at 2,6,10,14. Toggle period 2 with a 4-edge gap means every
    // accepted edge samples the same phase, so all four are rising.
    mode_b = M_BOTH;
    for (int k = 0; k < 20; k++) begin
      in_b = (k < 16 && k % 2 == 0) ? 8'h01 : 8'h00;
      tick();
      chk($sformatf("b_tog_evt%0d", k), evt_b,
          (k >= 2 && k <= 17 && (k - 2) % 4 == 0) ? 8'h01 : 8'h00);
      chk($sformatf("b_tog_fall%0d", k), fall_b, 8'h00);
    end
    chk("b_tog_cnt", cnt_b, 4'd4);

    // All channels rise together.
    in_b = 8'hFF;
    repeat (3) tick();
    chk("b_all_rise_evt", evt_b, 8'hFF);
    chk("b_all_rise_rise", rise_b, 8'hFF);
    chk("b_all_rise_cnt", cnt_b, 4'd12);
    tick();
    chk("b_all_rise_pulse", evt_b, 8'h00);
    repeat (2) tick();
    // All fall: 12 + 8 saturates at 15.
    in_b = 8'h00;
    repeat (3) tick();
    chk("b_all_fall_evt", fall_b, 8'hFF);
    chk("b_sat_cnt", cnt_b, 4'd15);
    repeat (3) tick();
    in_b = 8'hFF;
    repeat (3) tick();
    chk("b_sat_evt", evt_b, 8'hFF);
    chk("b_sat_hold", cnt_b, 4'd15);
    repeat (3) tick();
    // cnt_clr in the same cycle as two events: count becomes 2.
    in_b = 8'hFC;
    repeat (2) tick();
    cclr_b = 1'b1;
    tick();
    cclr_b = 1'b0;
    chk("b_clr_evt", fall_b, 8'h03);
    chk("b_clr_cnt", cnt_b, 4'd2);
    tick();
    chk("b_clr_cnt_hold", cnt_b, 4'd2);
    repeat (3) tick();

    // Reset mid-lockout: outputs clear at once, warm-up applies again.
    in_b = 8'hFF;
    repeat (3) tick();
    chk("b_pre_rst_evt", rise_b, 8'h03);
    chk("b_pre_rst_sticky", sticky_b, 8'hFF);
    chk("b_pre_rst_cnt", cnt_b, 4'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("b_midrst_evt", evt_b, 8'h00);
    chk("b_midrst_rise", rise_b, 8'h00);
    chk("b_midrst_any", any_b, 1'b0);
    chk("b_midrst_sticky", sticky_b, 8'h00);
    chk("b_midrst_cnt", cnt_b, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("b_rewarm_evt%0d", k), evt_b, 8'h00);
    end
    in_b = 8'hFB;
    repeat (3) tick();
    chk("b_post_evt", evt_b, 8'h04);
    chk("b_post_fall", fall_b, 8'h04);
    chk("b_post_sticky", sticky_b, 8'h04);
    chk("b_post_cnt", cnt_b, 4'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
